// File: rtl/stl_pkg.sv
// Shared constants for the STL UART to TileLink-UL bridge: TL opcodes,
// command/response packet field positions, FSM encoding and packing helpers.
package stl_pkg;

  // TileLink-UL A-channel opcodes
  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_GET             = 3'd4;
  // TileLink-UL D-channel opcodes
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  // Command packet field LSBs
  localparam int PKT_OP_LSB   = 0;
  localparam int PKT_SIZE_LSB = 8;
  localparam int PKT_SRC_LSB  = 16;
  localparam int PKT_MASK_LSB = 24;
  localparam int PKT_ADDR_LSB = 32;
  localparam int PKT_DATA_LSB = 64;

  // Response packet flag bits
  localparam int RSP_DENIED_BIT  = 3;
  localparam int RSP_CORRUPT_BIT = 4;
  localparam int RSP_LERR_BIT    = 5;
  localparam int RSP_TMO_BIT     = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_D,
    ST_RESP
  } state_e;

  // Only PutFull/PutPartial/Get with at most an 8-byte beat are forwarded.
  function automatic logic cmd_legal(logic [2:0] op, logic [3:0] size);
    return ((op == TL_PUT_FULL) || (op == TL_PUT_PARTIAL) || (op == TL_GET)) &&
           (size <= 4'd3);
  endfunction

  // Assemble a response packet; unnamed bits are forced to zero.
  function automatic logic [127:0] pack_rsp(
    logic [2:0]  op,
    logic        denied,
    logic        corrupt,
    logic        lerr,
    logic        tmo,
    logic [3:0]  size,
    logic [7:0]  src,
    logic [31:0] addr,
    logic [63:0] data
  );
    logic [127:0] r;
    r = '0;
    r[2:0]                 = op;
    r[RSP_DENIED_BIT]      = denied;
    r[RSP_CORRUPT_BIT]     = corrupt;
    r[RSP_LERR_BIT]        = lerr;
    r[RSP_TMO_BIT]         = tmo;
    r[11:8]                = size;
    r[23:16]               = src;
    r[63:32]               = addr;
    r[127:64]              = data;
    return r;
  endfunction

endpackage

// File: rtl/stl_timeout_counter.sv
// Loadable, clearable down-counter; expire_o is high while the count sits at
// zero and the timeout is enabled.
module stl_timeout_counter #(
  parameter int W  = 17,
  parameter bit EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         clr_i,
  input  logic         dec_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;

  // Load has priority over clear; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        count_q <= '0;
    else if (load_i)                count_q <= load_val_i;
    else if (clr_i)                 count_q <= '0;
    else if (dec_i && count_q != '0) count_q <= count_q - 1'b1;
  end

  assign expire_o = EN && (count_q == '0);

endmodule

// File: rtl/stl_uart_tl_bridge.sv
// Bridge: one 16-byte command packet -> one TL-UL A beat, wait for the D beat,
// return a 16-byte response packet. One transaction in flight at a time.
module stl_uart_tl_bridge
  import stl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                packet_valid,
  output logic                packet_ready,
  input  logic [127:0]        packet_data,
  output logic                tl_response_valid,
  input  logic                tl_response_ready,
  output logic [127:0]        tl_response_data,
  output logic                tl_a_valid,
  input  logic                tl_a_ready,
  output logic [2:0]          tl_a_opcode,
  output logic [2:0]          tl_a_param,
  output logic [3:0]          tl_a_size,
  output logic [7:0]          tl_a_source,
  output logic [ADDR_W-1:0]   tl_a_address,
  output logic [DATA_W/8-1:0] tl_a_mask,
  output logic [DATA_W-1:0]   tl_a_data,
  input  logic                tl_d_valid,
  output logic                tl_d_ready,
  input  logic [2:0]          tl_d_opcode,
  input  logic [3:0]          tl_d_size,
  input  logic [7:0]          tl_d_source,
  input  logic                tl_d_denied,
  input  logic                tl_d_corrupt,
  input  logic [DATA_W-1:0]   tl_d_data
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LOAD = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [127:0]        resp_q, resp_d;
  logic [2:0]          a_op_q;
  logic [3:0]          a_size_q;
  logic [7:0]          a_src_q;
  logic [ADDR_W-1:0]   a_addr_q;
  logic [DATA_W/8-1:0] a_mask_q;
  logic [DATA_W-1:0]   a_data_q;
  logic                cnt_load, cnt_dec, cnt_clr, cnt_expire;
  logic                pkt_fire;

  logic [2:0]          pkt_op;
  logic [3:0]          pkt_size;
  logic [7:0]          pkt_src;
  logic [ADDR_W-1:0]   pkt_addr;

  assign pkt_op   = packet_data[PKT_OP_LSB +: 3];
  assign pkt_size = packet_data[PKT_SIZE_LSB +: 4];
  assign pkt_src  = packet_data[PKT_SRC_LSB +: 8];
  assign pkt_addr = packet_data[PKT_ADDR_LSB +: ADDR_W];
  assign pkt_fire = (state_q == ST_IDLE) && packet_valid;

  // Reserved command bits are deliberately ignored.
  logic unused_pkt_bits;
  assign unused_pkt_bits = ^{packet_data[7:3], packet_data[15:12]};

  stl_timeout_counter #(
    .W  (CW),
    .EN (TIMEOUT_CYCLES != 0)
  ) u_tmo (
    .clk        (clk),
    .rst        (reset),
    .load_i     (cnt_load),
    .load_val_i (TO_LOAD),
    .clr_i      (cnt_clr),
    .dec_i      (cnt_dec),
    .expire_o   (cnt_expire)
  );

  // State register and response holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
    end
  end

  // A-channel fields are captured at packet fire and held through REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_op_q   <= '0;
      a_size_q <= '0;
      a_src_q  <= '0;
      a_addr_q <= '0;
      a_mask_q <= '0;
      a_data_q <= '0;
    end else if (pkt_fire) begin
      a_op_q   <= pkt_op;
      a_size_q <= pkt_size;
      a_src_q  <= pkt_src;
      a_addr_q <= pkt_addr;
      a_mask_q <= packet_data[PKT_MASK_LSB +: DATA_W/8];
      a_data_q <= packet_data[PKT_DATA_LSB +: DATA_W];
    end
  end

  // Next-state and response assembly; a D beat beats a coincident timeout.
  always_comb begin
    state_d  = state_q;
    resp_d   = resp_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (packet_valid) begin
          if (cmd_legal(pkt_op, pkt_size)) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_RESP;
            resp_d  = pack_rsp(pkt_op, 1'b0, 1'b0, 1'b1, 1'b0, pkt_size,
                               pkt_src, 32'(pkt_addr), 64'h0);
          end
        end
      end
      ST_REQ: begin
        if (tl_a_ready) begin
          state_d  = ST_WAIT_D;
          cnt_load = 1'b1;
        end
      end
      ST_WAIT_D: begin
        cnt_dec = 1'b1;
        if (tl_d_valid) begin
          state_d = ST_RESP;
          resp_d  = pack_rsp(tl_d_opcode, tl_d_denied, tl_d_corrupt,
                             tl_d_source != a_src_q, 1'b0, tl_d_size,
                             tl_d_source, 32'(a_addr_q), 64'(tl_d_data));
        end else if (cnt_expire) begin
          state_d = ST_RESP;
          resp_d  = pack_rsp(TL_ACCESS_ACK, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0,
                             8'h0, 32'(a_addr_q), 64'h0);
        end
      end
      ST_RESP: begin
        cnt_clr = 1'b1;
        if (tl_response_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign packet_ready      = (state_q == ST_IDLE);
  assign tl_a_valid        = (state_q == ST_REQ);
  assign tl_d_ready        = (state_q == ST_IDLE) || (state_q == ST_WAIT_D);
  assign tl_response_valid = (state_q == ST_RESP);
  assign tl_response_data  = resp_q;
  assign tl_a_opcode       = a_op_q;
  assign tl_a_param        = 3'd0;
  assign tl_a_size         = a_size_q;
  assign tl_a_source       = a_src_q;
  assign tl_a_address      = a_addr_q;
  assign tl_a_mask         = a_mask_q;
  assign tl_a_data         = a_data_q;

endmodule
